comram_arbiter: RTL and testbench

Arbitrates the 2 KB communication RAM shared by the main CPU and the extension CPU. Sits directly downstream of the address decoder and consumes its `mcpu_exit_en` (F800-FFFF) and `ecpu_ext_en` (8000-BFFF) selects. It serialises accesses from both CPUs onto one single-port RAM, stalls each CPU through an active-low wait, and returns latched read data.

---
 rtl/comram_pkg.sv | 17 +
 rtl/comram_spram.sv | 29 ++
 rtl/comram_arbiter.sv | 152 +++++++++++++++
 tb/tb_comram_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/comram_pkg.sv
// comram_pkg: shared types and constants for the communication-RAM arbiter.
package comram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } comram_state_e;

    localparam int COMRAM_AW = 11;
    localparam int COMRAM_DW = 8;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/comram_spram.sv
// comram_spram: single-port synchronous RAM, 2^AW x DW, registered read,
// write-first (a write returns the written data on the read port).
module comram_spram #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          cs_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o
);

    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    // Array access on chip select; contents are never cleared.
    always_ff @(posedge clk_i) begin
        if (cs_i) begin
            if (we_i) begin
                mem_q[addr_i] <= din_i;
                dout_o        <= din_i;
            end else begin
                dout_o        <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/comram_arbiter.sv
// comram_arbiter: serialises main-CPU (port A) and extension-CPU (port B)
// accesses onto one single-port RAM, stalling each CPU with an active-low
// wait and returning latched read data.
// Build option: define COMRAM_RR_EN for round-robin arbitration on
// contention; otherwise port A has fixed priority.
module comram_arbiter
    import comram_pkg::*;
#(
    parameter int AW = COMRAM_AW,
    parameter int DW = COMRAM_DW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic [DW-1:0] a_dout,
    output logic          a_wait_n,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic [DW-1:0] b_dout,
    output logic          b_wait_n,
    output logic          owner
);

    comram_state_e state_q, state_d;
    logic [1:0]    served_q, served_d;
    logic [1:0]    pend;
    logic          pick;
    logic          win_q;
    logic          owner_q;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic [DW-1:0] a_dout_q, b_dout_q;
    logic          ram_cs;
    logic [DW-1:0] ram_rdata;
    logic          grant;

`ifdef COMRAM_RR_EN
    // Distinguishes "no grant yet since reset" so the first contention goes to A.
    logic granted_q;
`endif

    // Pending requests and winner selection.
    always_comb begin
        pend         = 2'b00;
        pend[PORT_A] = a_req & ~served_q[PORT_A];
        pend[PORT_B] = b_req & ~served_q[PORT_B];
        grant        = (state_q == IDLE) && (pend != 2'b00);
`ifdef COMRAM_RR_EN
        if (pend == 2'b11) begin
            pick = granted_q ? ~owner_q : PORT_A;
        end else begin
            pick = pend[PORT_B] ? PORT_B : PORT_A;
        end
`else
        pick = pend[PORT_A] ? PORT_A : PORT_B;
`endif
        ram_addr_d = (pick == PORT_B) ? b_addr : a_addr;
        ram_we_d   = (pick == PORT_B) ? b_we   : a_we;
        ram_din_d  = (pick == PORT_B) ? b_din  : a_din;
    end

    // Served flags: set on completion, cleared whenever the request is low.
    always_comb begin
        served_d = served_q;
        if (!a_req) served_d[PORT_A] = 1'b0;
        if (!b_req) served_d[PORT_B] = 1'b0;
        if (state_q == ACCESS) served_d[win_q] = 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk_sys) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic: one fixed four-cycle slot per access.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pend != 2'b00) state_d = GRANT;
            GRANT:   state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: RAM strobe and CPU stall lines.
    always_comb begin
        ram_cs   = (state_q == GRANT);
        a_wait_n = reset | ~(a_req & ~served_q[PORT_A]);
        b_wait_n = reset | ~(b_req & ~served_q[PORT_B]);
    end

    // Control and read-data registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            served_q  <= 2'b00;
            owner_q   <= PORT_A;
            a_dout_q  <= '0;
            b_dout_q  <= '0;
`ifdef COMRAM_RR_EN
            granted_q <= 1'b0;
`endif
        end else begin
            served_q <= served_d;
            if (grant) begin
                owner_q   <= pick;
`ifdef COMRAM_RR_EN
                granted_q <= 1'b1;
`endif
            end
            if (state_q == ACCESS && !ram_we_q) begin
                if (win_q == PORT_B) b_dout_q <= ram_rdata;
                else                 a_dout_q <= ram_rdata;
            end
        end
    end

    // RAM port registers, loaded with the winner's request at grant.
    always_ff @(posedge clk_sys) begin
        if (grant) begin
            win_q      <= pick;
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_din_q  <= ram_din_d;
        end
    end

    comram_spram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk_i  (clk_sys),
        .cs_i   (ram_cs),
        .we_i   (ram_we_q),
        .addr_i (ram_addr_q),
        .din_i  (ram_din_q),
        .dout_o (ram_rdata)
    );

    assign a_dout = a_dout_q;
    assign b_dout = b_dout_q;
    assign owner  = owner_q;

endmodule

// File: tb/tb_comram_arbiter.sv
// tb_comram_arbiter: directed bench for comram_arbiter with a slot-level
// reference model compared every cycle plus literal expectations.
module tb_comram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        a_req   = 1'b0;
    logic        a_we    = 1'b0;
    logic [10:0] a_addr  = '0;
    logic [7:0]  a_din   = '0;
    logic [7:0]  a_dout;
    logic        a_wait_n;
    logic        b_req   = 1'b0;
    logic        b_we    = 1'b0;
    logic [10:0] b_addr  = '0;
    logic [7:0]  b_din   = '0;
    logic [7:0]  b_dout;
    logic        b_wait_n;
    logic        owner;

    int errors = 0;
    int checks = 0;

    comram_arbiter dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_dout   (a_dout),
        .a_wait_n (a_wait_n),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_din    (b_din),
        .b_dout   (b_dout),
        .b_wait_n (b_wait_n),
        .owner    (owner)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each access occupies a 4-cycle slot: decision, RAM sample, result, gap.
    logic [7:0]  mm [0:2047];
    int          m_slot = 0;
    bit          m_on = 0;
    bit          m_win, m_we, m_owner, m_any;
    logic [10:0] m_addr;
    logic [7:0]  m_din, m_rd;
    bit   [1:0]  m_srv;
    logic [7:0]  m_dout [0:1];

    always @(posedge clk_sys) begin
        bit [1:0] req;
        bit [1:0] pend;
        bit       done;
        req  = {b_req, a_req};
        done = 1'b0;
        if (reset) begin
            if (m_on && m_slot == 1 && m_we) mm[m_addr] = m_din;
            m_slot = 0; m_srv = 2'b00; m_dout[0] = 8'h00; m_dout[1] = 8'h00;
            m_owner = 1'b0; m_any = 1'b0; m_on = 1'b1;
        end else if (m_on) begin
            pend = req & ~m_srv;
            case (m_slot)
                0: if (pend != 2'b00) begin
`ifdef COMRAM_RR_EN
                    if (pend == 2'b11) m_win = m_any ? !m_owner : 1'b0;
                    else               m_win = pend[1];
`else
                    m_win = !pend[0];
`endif
                    m_we   = m_win ? b_we   : a_we;
                    m_addr = m_win ? b_addr : a_addr;
                    m_din  = m_win ? b_din  : a_din;
                    m_owner = m_win; m_any = 1'b1; m_slot = 1;
                end
                1: begin
                    if (m_we) mm[m_addr] = m_din;
                    m_rd = mm[m_addr];
                    m_slot = 2;
                end
                2: begin
                    if (!m_we) m_dout[m_win] = m_rd;
                    done = 1'b1;
                    m_slot = 3;
                end
                default: m_slot = 0;
            endcase
            for (int p = 0; p < 2; p++) begin
                if (done && m_win == p[0]) m_srv[p] = 1'b1;
                else if (!req[p])          m_srv[p] = 1'b0;
            end
        end
        #1;
        if (m_on) begin
            chk("model_a_wait_n", a_wait_n, reset ? 1'b1 : !(a_req && !m_srv[0]));
            chk("model_b_wait_n", b_wait_n, reset ? 1'b1 : !(b_req && !m_srv[1]));
            chk("model_a_dout", a_dout, m_dout[0]);
            chk("model_b_dout", b_dout, m_dout[1]);
            chk("model_owner", owner, m_owner);
        end
    end

    // ---------------- stimulus ----------------
    // Raise requests on the enabled ports, count stall cycles of each, then drop.
    task automatic access2(
        input bit ea, input bit awe, input logic [10:0] aad, input logic [7:0] adi,
        input bit eb, input bit bwe, input logic [10:0] bad, input logic [7:0] bdi,
        output int la, output int lb);
        bit ad, bd;
        @(negedge clk_sys);
        if (ea) begin a_req = 1'b1; a_we = awe; a_addr = aad; a_din = adi; end
        if (eb) begin b_req = 1'b1; b_we = bwe; b_addr = bad; b_din = bdi; end
        la = 0; lb = 0; ad = !ea; bd = !eb;
        #1;
        for (int cyc = 0; cyc < 30 && !(ad && bd); cyc++) begin
            if (!ad) begin if (a_wait_n) ad = 1'b1; else la++; end
            if (!bd) begin if (b_wait_n) bd = 1'b1; else lb++; end
            if (!(ad && bd)) begin @(posedge clk_sys); #2; end
        end
        chk("release_within_bound", {ad, bd}, 2'b11);
        @(negedge clk_sys);
        if (ea) a_req = 1'b0;
        if (eb) b_req = 1'b0;
        @(negedge clk_sys);
    endtask

    initial begin
        int la, lb;
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        #1;
        chk("reset_a_dout", a_dout, 8'h00);
        chk("reset_b_dout", b_dout, 8'h00);
        chk("reset_owner", owner, 1'b0);
        chk("reset_a_wait_n", a_wait_n, 1'b1);
        chk("reset_b_wait_n", b_wait_n, 1'b1);

        // A writes then reads back 0x010
        access2(1, 1, 11'h010, 8'h5A, 0, 0, 11'h000, 8'h00, la, lb);
        chk("a_write_latency", la, 3);
        access2(1, 0, 11'h010, 8'h00, 0, 0, 11'h000, 8'h00, la, lb);
        chk("a_read_latency", la, 3);
        chk("a_read_data", a_dout, 8'h5A);

        // simultaneous: A writes 0x11, B reads same address 0x7FF
        access2(1, 1, 11'h7FF, 8'h11, 1, 0, 11'h7FF, 8'h00, la, lb);
        chk("contend_a_latency", la, 3);
        chk("contend_b_latency", lb, 7);
        chk("contend_b_data", b_dout, 8'h11);

        // four rounds of simultaneous reads
        for (int r = 0; r < 4; r++) begin
            access2(1, 0, 11'h010, 8'h00, 1, 0, 11'h7FF, 8'h00, la, lb);
            chk("round_a_latency", la, 3);
            chk("round_b_latency", lb, 7);
            chk("round_a_data", a_dout, 8'h5A);
            chk("round_b_data", b_dout, 8'h11);
        end

        // A holds req after release: no repeat access
        @(negedge clk_sys);
        a_req = 1'b1; a_we = 1'b0; a_addr = 11'h010;
        #1;
        for (int i = 0; i < 10 && !a_wait_n; i++) begin @(posedge clk_sys); #2; end
        chk("hold_first_release", a_wait_n, 1'b1);
        repeat (4) begin @(posedge clk_sys); #2; chk("hold_a_wait_n", a_wait_n, 1'b1); end
        access2(0, 0, 11'h000, 8'h00, 1, 0, 11'h7FF, 8'h00, la, lb);
        chk("hold_b_latency", lb, 3);
        chk("hold_b_data", b_dout, 8'h11);
        @(negedge clk_sys); a_req = 1'b0;
        @(negedge clk_sys);
        access2(1, 0, 11'h010, 8'h00, 0, 0, 11'h000, 8'h00, la, lb);
        chk("rereq_a_latency", la, 3);

        // reset during GRANT of a B read
        @(negedge clk_sys);
        b_req = 1'b1; b_we = 1'b0; b_addr = 11'h010;
        @(negedge clk_sys);
        reset = 1'b1;
        @(posedge clk_sys); #2;
        chk("midreset_b_dout", b_dout, 8'h00);
        chk("midreset_a_wait_n", a_wait_n, 1'b1);
        chk("midreset_b_wait_n", b_wait_n, 1'b1);
        @(negedge clk_sys);
        reset = 1'b0;
        #1;
        lb = 0;
        for (int i = 0; i < 20 && !b_wait_n; i++) begin lb++; @(posedge clk_sys); #2; end
        chk("postreset_b_latency", lb, 3);
        chk("postreset_b_data", b_dout, 8'h5A);
        @(negedge clk_sys); b_req = 1'b0;
        @(negedge clk_sys);

        // B writes 0x3FF, then A reads it while B reads elsewhere
        access2(0, 0, 11'h000, 8'h00, 1, 1, 11'h3FF, 8'hA5, la, lb);
        chk("b_write_latency", lb, 3);
        chk("b_write_keeps_dout", b_dout, 8'h5A);
        access2(1, 0, 11'h3FF, 8'h00, 1, 0, 11'h7FF, 8'h00, la, lb);
        chk("cross_a_data", a_dout, 8'hA5);
        chk("cross_b_data", b_dout, 8'h11);
        chk("cross_a_latency", la, 3);
        chk("cross_b_latency", lb, 7);

        repeat (3) @(negedge clk_sys);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
